// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencer for the 5-stage core. It handles the load-use bubble, the
// data-memory wait freeze, taken-branch flushes and the debug halt handshake.
// It also keeps saturating stall and flush counters.
// The pipeline enables are combinational from the current state and inputs.
// The state, halt_ack, the timeout flag and the counters are registered.
module hazard_stall_controller #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_bubble,
    output logic              ex_mem_we,
    output logic              mem_wb_bubble,
    output logic              halt_ack,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(MEM_TMO);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_halt_ack;
    logic              r_mem_timeout;
    logic [15:0]       r_wait_cnt;
    logic [15:0]       w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_lu_hz;
    logic              w_mfreeze;
    logic              w_flush_evt;
    logic              w_stall_evt;
    logic              w_wait_evt;

    // The ID instruction reads the register that a load in EX has not yet produced.
    // x0 never creates a dependency.
    assign w_lu_hz = id_ex_is_load && (id_ex_rd != '0) &&
                     ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                      (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    assign w_mfreeze = mem_req && !mem_ready;

    // Next-state logic and pipeline controls, prioritized: freeze, then branch, then halt entry, then load-use.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt   = r_state;
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_bubble = 1'b0;
        w_flush_evt   = 1'b0;
        if (!reset) begin
            if (r_state == ST_HALTED) begin
                mem_wb_bubble = 1'b1;
                if (!halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end else if (w_mfreeze) begin
                // A branch or load-use hazard in flight stays put in its stage and is acted on at release.
                mem_wb_bubble = 1'b1;
                w_state_nxt   = ST_MEM_WAIT;
            end else begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                w_state_nxt = ST_RUN;
                if (ex_branch_taken) begin
                    // The ID instruction is on the wrong path, so its load-use hazard is irrelevant.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_flush_evt  = 1'b1;
                end else if (halt_req) begin
                    // The halt entry cycle lets the pipeline advance normally.
                    w_state_nxt = ST_HALTED;
                end else if (w_lu_hz) begin
                    // A single bubble is enough because the load result is forwarded from WB.
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        end
    end

    assign w_stall_evt = !reset && !pc_we && (r_state != ST_HALTED);
    assign w_wait_evt  = w_mfreeze && (r_state != ST_HALTED);

    // The wait count covers the frozen cycles of the current episode, so the entry cycle counts as 1.
    assign w_wait_nxt = (r_state != ST_MEM_WAIT) ? 16'd1 :
                        (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    // State register; halt_ack mirrors the registered HALTED state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            r_state    <= ST_RUN;
            r_halt_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_halt_ack <= (w_state_nxt == ST_HALTED);
        end
    end

    // Memory-wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_wait_evt) begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == TMO_LIMIT) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign halt_ack    = r_halt_ack;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller.
// A behavioural model tracks the mode, counters and timeout flag.
// It derives the expected pipeline controls from the priority rules.
module tb_hazard_stall_controller;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int MEM_TMO = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
    localparam logic [6:0] C_ZERO   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0001110;
    localparam logic [6:0] C_NORMAL = 7'b1101010;

    logic clk = 1'b0;
    logic reset;
    logic [REG_AW-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic if_id_use_rs1, if_id_use_rs2, id_ex_is_load, ex_branch_taken;
    logic mem_req, mem_ready, halt_req;
    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble;
    logic halt_ack, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef enum {M_RUN, M_WAIT, M_HALT} mode_t;
    mode_t m_mode;
    int    m_wait;
    bit    m_tmo;
    int    m_stall;
    int    m_flush;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_is_load(id_ex_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .halt_req(halt_req),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
        .mem_wb_bubble(mem_wb_bubble), .halt_ack(halt_ack), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [6:0] dut_ctl();
        return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};
    endfunction

    function automatic bit model_lu();
        return id_ex_is_load && (id_ex_rd != 0) &&
               ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    endfunction

    function automatic logic [6:0] exp_ctl();
        bit mf;
        mf = mem_req && !mem_ready;
        if (reset) return C_ZERO;
        if (m_mode == M_HALT || mf) return C_FREEZE;
        if (ex_branch_taken) return C_BRANCH;
        if (halt_req) return C_NORMAL;
        if (model_lu()) return C_LU;
        return C_NORMAL;
    endfunction

    task automatic idle_inputs();
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
        if_id_use_rs1 = 0; if_id_use_rs2 = 0; id_ex_is_load = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_wait = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance one clock. Outputs are checked at negedge+1 before calling.
    task automatic tick();
        logic [6:0] ctl;
        bit mf;
        ctl = exp_ctl();
        mf  = mem_req && !mem_ready;
        @(posedge clk);
        if (!reset) begin
            if (m_mode != M_HALT && !ctl[6] && m_stall < CNT_MAX) m_stall++;
            if (m_mode != M_HALT && !mf && ex_branch_taken && m_flush < CNT_MAX) m_flush++;
            if (m_mode == M_HALT) begin
                m_mode = halt_req ? M_HALT : M_RUN;
            end else if (mf) begin
                m_wait = (m_mode == M_RUN) ? 1 : ((m_wait < 65535) ? m_wait + 1 : m_wait);
                if (m_wait == MEM_TMO) m_tmo = 1;
                m_mode = M_WAIT;
            end else begin
                m_mode = (halt_req && !ex_branch_taken) ? M_HALT : M_RUN;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        model_reset();
        #1;
        if (dut_ctl() !== C_ZERO) begin errors++; $display("FAIL reset_ctl: got %b expected %b", dut_ctl(), C_ZERO); end
        checks++;
        if ({halt_ack, mem_timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {halt_ack, mem_timeout}); end
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        checks++;
        @(negedge clk);
        reset = 0;
        #1;
        if (dut_ctl() !== C_NORMAL) begin errors++; $display("FAIL post_reset_ctl: got %b expected %b", dut_ctl(), C_NORMAL); end
        checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_is_load = 1; id_ex_rd = 5; if_id_rs1 = 5; if_id_use_rs1 = 1; if_id_rs2 = 1; if_id_use_rs2 = 1;
        #1;
        if (dut_ctl() !== C_LU || exp_ctl() !== C_LU) begin errors++; $display("FAIL load_use_ctl: got %b expected %b", dut_ctl(), C_LU); end
        checks++;
        tick();
        id_ex_is_load = 0; id_ex_rd = 6;
        #1;
        if (dut_ctl() !== C_NORMAL) begin errors++; $display("FAIL load_use_after: got %b expected %b", dut_ctl(), C_NORMAL); end
        checks++;
        if (stall_cnt !== 1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
        checks++;
        tick();
    endtask

    task automatic test_no_stall();
        // {rd, rs1, use_rs1, rs2, use_rs2, expected control}
        logic [REG_AW-1:0] rd_t[4]  = '{5'd0, 5'd5, 5'd7, 5'd9};
        logic [REG_AW-1:0] rs1_t[4] = '{5'd0, 5'd5, 5'd1, 5'd2};
        logic              u1_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [REG_AW-1:0] rs2_t[4] = '{5'd0, 5'd3, 5'd7, 5'd3};
        logic              u2_t[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [6:0]        ex_t[4]  = '{C_NORMAL, C_NORMAL, C_LU, C_NORMAL};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            id_ex_is_load = 1; id_ex_rd = rd_t[i];
            if_id_rs1 = rs1_t[i]; if_id_use_rs1 = u1_t[i];
            if_id_rs2 = rs2_t[i]; if_id_use_rs2 = u2_t[i];
            #1;
            if (dut_ctl() !== ex_t[i]) begin errors++; $display("FAIL no_stall_%0d: got %b expected %b", i, dut_ctl(), ex_t[i]); end
            checks++;
            tick();
        end
        idle_inputs();
        // Branch beats a simultaneous load-use hazard.
        id_ex_is_load = 1; id_ex_rd = 4; if_id_rs2 = 4; if_id_use_rs2 = 1; ex_branch_taken = 1;
        #1;
        if (dut_ctl() !== C_BRANCH) begin errors++; $display("FAIL branch_over_lu: got %b expected %b", dut_ctl(), C_BRANCH); end
        checks++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (dut_ctl() !== C_FREEZE) begin errors++; $display("FAIL mem_freeze_%0d: got %b expected %b", i, dut_ctl(), C_FREEZE); end
            checks++;
            tick();
        end
        mem_ready = 1;
        #1;
        if (dut_ctl() !== C_NORMAL) begin errors++; $display("FAIL mem_release: got %b expected %b", dut_ctl(), C_NORMAL); end
        checks++;
        tick();
        idle_inputs();
        #1;
        if (stall_cnt !== 3) begin errors++; $display("FAIL mem_stall_cnt: got %0d expected 3", stall_cnt); end
        checks++;
    endtask

    task automatic test_branch_in_freeze();
        do_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (dut_ctl() !== C_FREEZE) begin errors++; $display("FAIL br_freeze_%0d: got %b expected %b", i, dut_ctl(), C_FREEZE); end
            checks++;
            tick();
        end
        mem_ready = 1;
        #1;
        if (dut_ctl() !== C_BRANCH) begin errors++; $display("FAIL br_release: got %b expected %b", dut_ctl(), C_BRANCH); end
        checks++;
        tick();
        idle_inputs();
        #1;
        if (dut_ctl() !== C_NORMAL) begin errors++; $display("FAIL br_after: got %b expected %b", dut_ctl(), C_NORMAL); end
        checks++;
        if (flush_cnt !== 1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt); end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            #1;
            if (mem_timeout !== (k >= MEM_TMO)) begin
                errors++; $display("FAIL tmo_cycle_%0d: got %b expected %b", k, mem_timeout, k >= MEM_TMO);
            end
            checks++;
        end
        mem_ready = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        #1;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", mem_timeout); end
        checks++;
        do_reset();
        #1;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_reset: got %b expected 0", mem_timeout); end
        checks++;
    endtask

    task automatic test_halt_in_wait();
        do_reset();
        mem_req = 1; mem_ready = 0; halt_req = 1;
        repeat (2) tick();
        mem_ready = 1;
        #1;
        if (dut_ctl() !== C_NORMAL || halt_ack !== 1'b0) begin
            errors++; $display("FAIL halt_release: got %b/%b expected %b/0", dut_ctl(), halt_ack, C_NORMAL);
        end
        checks++;
        tick();
        mem_req = 0; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (halt_ack !== 1'b1 || dut_ctl() !== C_FREEZE) begin
                errors++; $display("FAIL halted_%0d: got ack=%b ctl=%b expected ack=1 ctl=%b", i, halt_ack, dut_ctl(), C_FREEZE);
            end
            checks++;
            tick();
        end
        halt_req = 0;
        #1;
        if (halt_ack !== 1'b1) begin errors++; $display("FAIL halt_drop_cycle: got %b expected 1", halt_ack); end
        checks++;
        tick();
        #1;
        if (halt_ack !== 1'b0 || dut_ctl() !== C_NORMAL) begin
            errors++; $display("FAIL halt_resume: got ack=%b ctl=%b expected ack=0 ctl=%b", halt_ack, dut_ctl(), C_NORMAL);
        end
        checks++;
        if (stall_cnt !== 2) begin errors++; $display("FAIL halt_stall_cnt: got %0d expected 2", stall_cnt); end
        checks++;
        // Asynchronous reset while halted returns straight to RUN.
        halt_req = 1;
        tick();
        #2;
        reset = 1;
        halt_req = 0;
        model_reset();
        #1;
        if (halt_ack !== 1'b0 || dut_ctl() !== C_ZERO) begin
            errors++; $display("FAIL reset_in_halt: got ack=%b ctl=%b expected ack=0 ctl=%b", halt_ack, dut_ctl(), C_ZERO);
        end
        checks++;
        @(negedge clk);
        reset = 0;
        #1;
        if (dut_ctl() !== C_NORMAL) begin errors++; $display("FAIL reset_in_halt_run: got %b expected %b", dut_ctl(), C_NORMAL); end
        checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        id_ex_is_load = 1; id_ex_rd = 3; if_id_rs1 = 3; if_id_use_rs1 = 1;
        repeat (CNT_MAX + 5) tick();
        #1;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, CNT_MAX); end
        checks++;
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            id_ex_is_load   = ($urandom_range(0, 2) == 0);
            id_ex_rd        = REG_AW'($urandom_range(0, 3));
            if_id_rs1       = REG_AW'($urandom_range(0, 3));
            if_id_rs2       = REG_AW'($urandom_range(0, 3));
            if_id_use_rs1   = $urandom_range(0, 1) == 1;
            if_id_use_rs2   = $urandom_range(0, 1) == 1;
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
            #1;
            if (dut_ctl() !== exp_ctl()) begin errors++; $display("FAIL rand_ctl_%0d: got %b expected %b", n, dut_ctl(), exp_ctl()); end
            checks++;
            if (halt_ack !== (m_mode == M_HALT) || mem_timeout !== m_tmo) begin
                errors++; $display("FAIL rand_flags_%0d: got ack=%b tmo=%b expected ack=%b tmo=%b", n, halt_ack, mem_timeout, m_mode == M_HALT, m_tmo);
            end
            checks++;
            if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                errors++; $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            checks++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_no_stall();
        test_mem_wait();
        test_branch_in_freeze();
        test_timeout();
        test_halt_in_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
